// File: rtl/demux.sv
// rtl/demux.sv - 3-to-8 one-hot decoder with enable and optional output register
//
// Purpose:
//   Decodes the select index s = {a,b,c} (a is the MSB) into eight outputs.
//   With e=1 exactly one output dN (N = s) is high. With e=0 all outputs are low.
//   REG_OUT=0 gives purely combinational outputs. REG_OUT=1 registers the
//   decoded vector on every rising clk edge.
//
// Parameters:
//   REG_OUT  0 = combinational outputs, 1 = registered outputs (one-cycle latency)
//
// Ports:
//   clk      in   1  clock, used only when REG_OUT=1
//   rst_n    in   1  asynchronous active-low reset of the output register
//   a, b, c  in   1  select bits 2 (MSB), 1 and 0 (LSB)
//   e        in   1  enable, active-high
//   d0..d7   out  1  one-hot decoded outputs

module demux #(
  parameter bit REG_OUT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic e,
  output logic d0,
  output logic d1,
  output logic d2,
  output logic d3,
  output logic d4,
  output logic d5,
  output logic d6,
  output logic d7
);

  logic [2:0] sel;
  logic [7:0] dec_d;
  logic [7:0] out_vec;

  assign sel = {a, b, c};

  // A single bit is set only when enabled, so the vector is one-hot or all-zero.
  always_comb begin
    dec_d = 8'h00;
    if (e) begin
      dec_d[sel] = 1'b1;
    end
  end

  generate
    if (REG_OUT) begin : g_reg
      logic [7:0] out_q;

      // The register loads every cycle; there is no hold or stall path.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_q <= 8'h00;
        end else begin
          out_q <= dec_d;
        end
      end

      assign out_vec = out_q;
    end else begin : g_comb
      // clk and rst_n play no part in the combinational variant.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;

      assign out_vec = dec_d;
    end
  endgenerate

  assign d0 = out_vec[0];
  assign d1 = out_vec[1];
  assign d2 = out_vec[2];
  assign d3 = out_vec[3];
  assign d4 = out_vec[4];
  assign d5 = out_vec[5];
  assign d6 = out_vec[6];
  assign d7 = out_vec[7];

endmodule

// File: tb/tb_demux.sv
// tb/tb_demux.sv - self-checking bench for demux in both output modes

module tb_demux;

  logic clk;
  logic rst_n;
  logic a, b, c, e;
  logic [7:0] comb_o;
  logic [7:0] reg_o;

  int n_checks;
  int n_errors;

  demux #(.REG_OUT(1'b0)) u_comb (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .e(e),
    .d0(comb_o[0]), .d1(comb_o[1]), .d2(comb_o[2]), .d3(comb_o[3]),
    .d4(comb_o[4]), .d5(comb_o[5]), .d6(comb_o[6]), .d7(comb_o[7])
  );

  demux #(.REG_OUT(1'b1)) u_reg (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .e(e),
    .d0(reg_o[0]), .d1(reg_o[1]), .d2(reg_o[2]), .d3(reg_o[3]),
    .d4(reg_o[4]), .d5(reg_o[5]), .d6(reg_o[6]), .d7(reg_o[7])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sel;
    logic       en;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[16];

  // Reference: output N is high exactly when enabled and the select value equals N.
  function automatic logic [7:0] ref_decode(input logic [2:0] s, input logic en);
    logic [7:0] r;
    r = 8'h00;
    for (int n = 0; n < 8; n++) begin
      if (en && (int'(s) == n)) r = r | (8'h01 << n);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [2:0] s, input logic en);
    {a, b, c} = s;
    e = en;
  endtask

  logic [7:0] exp_reg;
  logic [2:0] rs;
  logic       re;

  initial begin
    n_checks = 0;
    n_errors = 0;

    // Hand-written expectations for all 16 {a,b,c,e} combinations.
    vecs[0]  = '{3'd0, 1'b1, 8'b0000_0001};
    vecs[1]  = '{3'd1, 1'b1, 8'b0000_0010};
    vecs[2]  = '{3'd2, 1'b1, 8'b0000_0100};
    vecs[3]  = '{3'd3, 1'b1, 8'b0000_1000};
    vecs[4]  = '{3'd4, 1'b1, 8'b0001_0000};
    vecs[5]  = '{3'd5, 1'b1, 8'b0010_0000};
    vecs[6]  = '{3'd6, 1'b1, 8'b0100_0000};
    vecs[7]  = '{3'd7, 1'b1, 8'b1000_0000};
    vecs[8]  = '{3'd0, 1'b0, 8'b0000_0000};
    vecs[9]  = '{3'd1, 1'b0, 8'b0000_0000};
    vecs[10] = '{3'd2, 1'b0, 8'b0000_0000};
    vecs[11] = '{3'd3, 1'b0, 8'b0000_0000};
    vecs[12] = '{3'd4, 1'b0, 8'b0000_0000};
    vecs[13] = '{3'd5, 1'b0, 8'b0000_0000};
    vecs[14] = '{3'd6, 1'b0, 8'b0000_0000};
    vecs[15] = '{3'd7, 1'b0, 8'b0000_0000};

    // Reset: registered outputs cleared, combinational outputs unaffected.
    rst_n = 1'b0;
    drive(3'd6, 1'b1);
    #1;
    check("reset_reg", reg_o, 8'h00);
    check("reset_comb_ignores_rst", comb_o, 8'b0100_0000);
    repeat (2) @(posedge clk);
    #1;
    check("reset_reg_across_edges", reg_o, 8'h00);

    // Release mid-cycle; the first edge loads the current decode.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_before_edge", reg_o, 8'h00);
    @(posedge clk);
    #1;
    check("release_first_edge", reg_o, 8'b0100_0000);

    // Table sweep: enable sweep and disable sweep, both modes.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(vecs[i].sel, vecs[i].en);
      #5;
      check($sformatf("table_comb[%0d]", i), comb_o, vecs[i].exp);
      @(posedge clk);
      #1;
      check($sformatf("table_reg[%0d]", i), reg_o, vecs[i].exp);
    end

    // Registered latency: value held until the edge, d3 after it.
    @(negedge clk);
    drive(3'd0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(3'd3, 1'b1);
    #1;
    check("latency_comb_now", comb_o, 8'b0000_1000);
    check("latency_reg_holds", reg_o, 8'b0000_0001);
    @(posedge clk);
    #1;
    check("latency_reg_after_edge", reg_o, 8'b0000_1000);

    // Async reset mid-operation.
    @(negedge clk);
    drive(3'd6, 1'b1);
    @(posedge clk);
    #1;
    check("async_pre_d6", reg_o, 8'b0100_0000);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear_immediate", reg_o, 8'h00);
    check("async_comb_unaffected", comb_o, 8'b0100_0000);
    drive(3'd2, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("async_hold_in_reset", reg_o, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("async_release_no_edge", reg_o, 8'h00);
    @(posedge clk);
    #1;
    check("async_release_load", reg_o, 8'b0000_0100);

    // Enable toggle on select 7.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(3'd7, (i % 2 == 0));
      @(posedge clk);
      #1;
      check($sformatf("toggle_reg[%0d]", i), reg_o, (i % 2 == 0) ? 8'h80 : 8'h00);
    end

    // Random one-hot check against the reference.
    @(negedge clk);
    drive(3'd0, 1'b0);
    @(posedge clk);
    exp_reg = 8'h00;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      rs = 3'($urandom_range(0, 7));
      re = 1'($urandom_range(0, 1));
      drive(rs, re);
      #1;
      check("rand_comb", comb_o, ref_decode(rs, re));
      check("rand_comb_popcount", 8'($countones(comb_o)), {7'd0, re});
      check("rand_reg_before_edge", reg_o, exp_reg);
      @(posedge clk);
      #1;
      exp_reg = ref_decode(rs, re);
      check("rand_reg", reg_o, exp_reg);
      check("rand_reg_popcount", 8'($countones(reg_o)), {7'd0, re});
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
